// File: rtl/rtc_read_sequencer.sv
// Reads the six date/time bytes out of the RTC: a RAM-transfer command, then
// one address/data pair per byte, each byte written into the local register file.
//
// state | meaning
// IDLE  | bus released, waiting for Inicie
// CMD_A | address phase of the RTC-to-RAM transfer command (F0h)
// CMD_D | dummy data phase of the transfer command (00h)
// RD_A  | address phase for register 21h+idx
// RD_D  | data phase: read strobe, capture, register-file write
// DONE  | one-cycle completion pulse, back to IDLE
module rtc_read_sequencer #(
    parameter int TW = 4
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Inicie,
    input  logic [7:0] DatoBusIn,
    output logic       ADF,
    output logic       CSF,
    output logic       RDF,
    output logic       WRF,
    output logic [7:0] DireccionF,
    output logic       SDF,
    output logic [3:0] AddRegF,
    output logic [7:0] DatoRegF,
    output logic       WeRegF,
    output logic       BusyF,
    output logic       ReadyF
);

    typedef enum logic [2:0] {IDLE, CMD_A, CMD_D, RD_A, RD_D, DONE} state_t;
    typedef enum logic [1:0] {SETUP, STROBE, HOLD, RECOVER} phase_t;

    localparam logic [3:0] CNT_LAST = 4'(TW - 1);

    state_t     state, state_n;
    phase_t     phase, phase_n;
    logic [3:0] cnt, cnt_n;
    logic [2:0] idx, idx_n;
    logic [7:0] cap, cap_n;
    logic       xfer_n, drive_n, write_n, we_n;
    logic [7:0] dir_n;

    always_comb begin
        state_n = state;
        phase_n = phase;
        cnt_n   = cnt;
        idx_n   = idx;
        cap_n   = cap;
        case (state)
            IDLE: begin
                if (Inicie) begin
                    state_n = CMD_A;
                    phase_n = SETUP;
                    cnt_n   = '0;
                    idx_n   = '0;
                end
            end
            DONE: begin
                state_n = IDLE;
                phase_n = SETUP;
                cnt_n   = '0;
                idx_n   = '0;
            end
            default: begin
                case (phase)
                    SETUP: begin
                        phase_n = STROBE;
                        cnt_n   = '0;
                    end
                    STROBE: begin
                        if (cnt == CNT_LAST) begin
                            phase_n = HOLD;
                            cnt_n   = '0;
                            if (state == RD_D) cap_n = DatoBusIn;
                        end else begin
                            cnt_n = cnt + 4'd1;
                        end
                    end
                    HOLD: begin
                        phase_n = RECOVER;
                        cnt_n   = '0;
                    end
                    default: begin
                        phase_n = SETUP;
                        cnt_n   = '0;
                        case (state)
                            CMD_A:   state_n = CMD_D;
                            CMD_D:   state_n = RD_A;
                            RD_A:    state_n = RD_D;
                            default: begin
                                if (idx == 3'd5) begin
                                    state_n = DONE;
                                end else begin
                                    idx_n   = idx + 3'd1;
                                    state_n = RD_A;
                                end
                            end
                        endcase
                    end
                endcase
            end
        endcase
    end

    // Outputs are decoded from the next state so each registered output lines
    // up with the sub-phase it belongs to, with no extra cycle of lag.
    always_comb begin
        xfer_n  = state_n inside {CMD_A, CMD_D, RD_A, RD_D};
        write_n = state_n inside {CMD_A, CMD_D, RD_A};
        drive_n = write_n && (phase_n != RECOVER);
        we_n    = (state_n == RD_D) && (phase_n == HOLD);
        case (state_n)
            CMD_A:   dir_n = 8'hF0;
            RD_A:    dir_n = 8'h21 + {5'b0, idx_n};
            default: dir_n = 8'h00;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state      <= IDLE;
            phase      <= SETUP;
            cnt        <= '0;
            idx        <= '0;
            cap        <= 8'h00;
            ADF        <= 1'b1;
            CSF        <= 1'b1;
            RDF        <= 1'b1;
            WRF        <= 1'b1;
            SDF        <= 1'b0;
            DireccionF <= 8'h00;
            WeRegF     <= 1'b0;
            AddRegF    <= 4'h0;
            DatoRegF   <= 8'h00;
            BusyF      <= 1'b0;
            ReadyF     <= 1'b0;
        end else begin
            state      <= state_n;
            phase      <= phase_n;
            cnt        <= cnt_n;
            idx        <= idx_n;
            cap        <= cap_n;
            ADF        <= !(state_n inside {CMD_A, RD_A});
            CSF        <= !(xfer_n && (phase_n != RECOVER));
            WRF        <= !(write_n && (phase_n == STROBE));
            RDF        <= !((state_n == RD_D) && (phase_n == STROBE));
            SDF        <= drive_n;
            DireccionF <= drive_n ? dir_n : 8'h00;
            WeRegF     <= we_n;
            AddRegF    <= we_n ? {1'b0, idx_n} : 4'h0;
            DatoRegF   <= we_n ? cap_n : 8'h00;
            BusyF      <= xfer_n;
            ReadyF     <= (state_n == DONE);
        end
    end

endmodule

// File: tb/tb_rtc_read_sequencer.sv
// Bench for rtc_read_sequencer: three instances (TW = 4, 2, 15) share a clock
// and reset; a monitor checks strobes, register writes and ReadyF timing.
`timescale 1ns/1ps
module tb_rtc_read_sequencer;

    typedef struct packed {logic [7:0] dat; logic adf;} wr_t;
    typedef struct packed {logic [3:0] addr; logic [7:0] dat;} we_t;

    logic       Clock = 1'b0;
    logic       Reset;
    logic [2:0] inicie;
    logic [7:0] bus_in [3];
    logic [2:0] adf, csf, rdf, wrf, sdf, we, busy, rdy;
    logic [7:0] dir [3];
    logic [7:0] dreg [3];
    logic [3:0] areg [3];

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    wr_t exp_wr[$];
    we_t exp_we[$];
    int  exp_rdy [3][4];
    int  rdy_wr [3] = '{0, 0, 0};
    int  rdy_rd [3] = '{0, 0, 0};

    int         wlen [3] = '{0, 0, 0};
    int         rlen [3] = '{0, 0, 0};
    int         post [3] = '{0, 0, 0};
    int         rdcnt [3] = '{0, 0, 0};
    logic [7:0] w_dat [3];
    logic       w_adf [3];
    logic [7:0] last_addr [3];

    rtc_read_sequencer #(.TW(4)) u_dut0 (
        .Clock(Clock), .Reset(Reset), .Inicie(inicie[0]), .DatoBusIn(bus_in[0]),
        .ADF(adf[0]), .CSF(csf[0]), .RDF(rdf[0]), .WRF(wrf[0]), .DireccionF(dir[0]),
        .SDF(sdf[0]), .AddRegF(areg[0]), .DatoRegF(dreg[0]), .WeRegF(we[0]),
        .BusyF(busy[0]), .ReadyF(rdy[0]));

    rtc_read_sequencer #(.TW(2)) u_dut1 (
        .Clock(Clock), .Reset(Reset), .Inicie(inicie[1]), .DatoBusIn(bus_in[1]),
        .ADF(adf[1]), .CSF(csf[1]), .RDF(rdf[1]), .WRF(wrf[1]), .DireccionF(dir[1]),
        .SDF(sdf[1]), .AddRegF(areg[1]), .DatoRegF(dreg[1]), .WeRegF(we[1]),
        .BusyF(busy[1]), .ReadyF(rdy[1]));

    rtc_read_sequencer #(.TW(15)) u_dut2 (
        .Clock(Clock), .Reset(Reset), .Inicie(inicie[2]), .DatoBusIn(bus_in[2]),
        .ADF(adf[2]), .CSF(csf[2]), .RDF(rdf[2]), .WRF(wrf[2]), .DireccionF(dir[2]),
        .SDF(sdf[2]), .AddRegF(areg[2]), .DatoRegF(dreg[2]), .WeRegF(we[2]),
        .BusyF(busy[2]), .ReadyF(rdy[2]));

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    function automatic int tw_of(input int d);
        case (d)
            0:       return 4;
            1:       return 2;
            default: return 15;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_seq0(input int n_addr, input int n_we);
        wr_t w;
        we_t r;
        w.dat = 8'hF0; w.adf = 1'b0; exp_wr.push_back(w);
        w.dat = 8'h00; w.adf = 1'b1; exp_wr.push_back(w);
        for (int i = 0; i < n_addr; i++) begin
            w.dat = 8'(8'h21 + i); w.adf = 1'b0; exp_wr.push_back(w);
        end
        for (int i = 0; i < n_we; i++) begin
            r.addr = 4'(i); r.dat = 8'(8'h10 + i); exp_we.push_back(r);
        end
    endtask

    task automatic push_rdy(input int d, input int abs_cyc);
        exp_rdy[d][rdy_wr[d] % 4] = abs_cyc;
        rdy_wr[d]++;
    endtask

    // Pulse Inicie for one cycle; n0 is the cycle count during SETUP of CMD_A.
    task automatic start(input int d, output int n0);
        @(negedge Clock);
        inicie[d] = 1'b1;
        @(negedge Clock);
        inicie[d] = 1'b0;
        n0 = cyc;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while ((rdy_rd[0] != rdy_wr[0] || rdy_rd[1] != rdy_wr[1] || rdy_rd[2] != rdy_wr[2])
               && n < budget) begin
            @(negedge Clock);
            n++;
        end
        chk("ready_pending_after_wait", 32'(rdy_wr[0] - rdy_rd[0] + rdy_wr[1] - rdy_rd[1]
            + rdy_wr[2] - rdy_rd[2]), 32'd0);
    endtask

    // Monitor and RTC model: the RTC answers a read with (last address - 11h),
    // i.e. 10h + idx for addresses 21h + idx.
    always @(negedge Clock) begin
        wr_t e_wr;
        we_t e_we;
        for (int d = 0; d < 3; d++) begin
            if (!Reset) begin
                wlen[d] = 0; rlen[d] = 0; post[d] = 0; rdcnt[d] = 0;
            end else begin
                chk("rd_wr_overlap", 32'(!rdf[d] && !wrf[d]), 32'd0);
                chk("sdf_during_read", 32'(sdf[d] && !rdf[d]), 32'd0);
                if (!busy[d]) chk("csf_idle", 32'(csf[d]), 32'd1);
                if (post[d] == 1) begin
                    chk("csf_recover", 32'(csf[d]), 32'd1);
                    post[d] = 0;
                end
                if (!wrf[d]) begin
                    if (wlen[d] == 0) begin
                        w_dat[d] = dir[d];
                        w_adf[d] = adf[d];
                        chk("sdf_in_write", 32'(sdf[d]), 32'd1);
                    end
                    wlen[d]++;
                    if (!adf[d]) begin
                        last_addr[d] = dir[d];
                        bus_in[d] = dir[d] - 8'h11;
                    end
                end else if (wlen[d] != 0) begin
                    chk("wr_width", 32'(wlen[d]), 32'(tw_of(d)));
                    chk("csf_hold_wr", 32'(csf[d]), 32'd0);
                    if (d == 0) begin
                        if (exp_wr.size() == 0) begin
                            chk("wr_unexpected", 32'(w_dat[d]), 32'hFFFF);
                        end else begin
                            e_wr = exp_wr.pop_front();
                            chk("wr_byte", 32'(w_dat[d]), 32'(e_wr.dat));
                            chk("wr_adf", 32'(w_adf[d]), 32'(e_wr.adf));
                        end
                    end
                    wlen[d] = 0;
                    post[d] = 1;
                end
                if (!rdf[d]) begin
                    if (rlen[d] == 0) chk("rd_adf", 32'(adf[d]), 32'd1);
                    rlen[d]++;
                end else if (rlen[d] != 0) begin
                    chk("rd_width", 32'(rlen[d]), 32'(tw_of(d)));
                    chk("csf_hold_rd", 32'(csf[d]), 32'd0);
                    chk("we_in_hold", 32'(we[d]), 32'd1);
                    chk("we_addr", 32'(areg[d]), 32'(rdcnt[d]));
                    chk("we_data", 32'(dreg[d]), 32'(last_addr[d] - 8'h11));
                    rdcnt[d]++;
                    rlen[d] = 0;
                    post[d] = 1;
                end
                if (d == 0 && we[d]) begin
                    if (exp_we.size() == 0) begin
                        chk("we_unexpected", 32'(areg[d]), 32'hFFFF);
                    end else begin
                        e_we = exp_we.pop_front();
                        chk("we_pop_addr", 32'(areg[d]), 32'(e_we.addr));
                        chk("we_pop_data", 32'(dreg[d]), 32'(e_we.dat));
                    end
                end
                if (rdy[d]) begin
                    if (rdy_rd[d] == rdy_wr[d]) begin
                        chk("ready_unexpected", 32'(cyc), 32'hFFFF_FFFF);
                    end else begin
                        chk("ready_cycle", 32'(cyc), 32'(exp_rdy[d][rdy_rd[d] % 4]));
                        chk("reads_before_ready", 32'(rdcnt[d]), 32'd6);
                        rdy_rd[d]++;
                    end
                    rdcnt[d] = 0;
                end
            end
        end
    end

    initial begin
        #60000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, n1, n2;
        Reset = 1'b0;
        inicie = 3'b000;
        for (int d = 0; d < 3; d++) begin
            bus_in[d] = 8'h00;
            last_addr[d] = 8'h00;
        end
        repeat (3) @(negedge Clock);
        chk("rst_adf", 32'(adf), 32'h7);
        chk("rst_csf", 32'(csf), 32'h7);
        chk("rst_rdf", 32'(rdf), 32'h7);
        chk("rst_wrf", 32'(wrf), 32'h7);
        chk("rst_sdf", 32'(sdf), 32'h0);
        chk("rst_we", 32'(we), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_ready", 32'(rdy), 32'h0);
        chk("rst_dir", 32'(dir[0]), 32'h00);
        chk("rst_dreg", 32'(dreg[0]), 32'h00);
        chk("rst_areg", 32'(areg[0]), 32'h0);
        #2 Reset = 1'b1;

        // All three widths in parallel; Inicie re-pulsed mid-sequence.
        start(0, n0);
        push_seq0(6, 6);
        push_rdy(0, n0 + 14 * 7);
        chk("c1_busy", 32'(busy[0]), 32'd1);
        chk("c1_csf", 32'(csf[0]), 32'd0);
        chk("c1_wrf_setup", 32'(wrf[0]), 32'd1);
        chk("c1_adf", 32'(adf[0]), 32'd0);
        start(1, n1);
        push_rdy(1, n1 + 14 * 5);
        chk("c3_wrf", 32'(wrf[0]), 32'd0);
        chk("c3_dir", 32'(dir[0]), 32'hF0);
        start(2, n2);
        push_rdy(2, n2 + 14 * 18);
        while (cyc < n0 + 39) @(negedge Clock);
        inicie = 3'b111;
        @(negedge Clock);
        inicie = 3'b000;
        wait_done(400);
        @(negedge Clock);
        chk("idle_after_done", 32'(busy), 32'h0);

        // Reset during the RD_D strobe of idx 3.
        start(0, n0);
        push_seq0(4, 3);
        while (cyc < n0 + 65) @(negedge Clock);
        chk("rd3_strobe_active", 32'(rdf[0]), 32'd0);
        #2 Reset = 1'b0;
        #1;
        chk("abort_csf", 32'(csf[0]), 32'd1);
        chk("abort_rdf", 32'(rdf[0]), 32'd1);
        chk("abort_wrf", 32'(wrf[0]), 32'd1);
        chk("abort_we", 32'(we[0]), 32'd0);
        chk("abort_busy", 32'(busy[0]), 32'd0);
        chk("abort_ready", 32'(rdy[0]), 32'd0);
        repeat (4) @(negedge Clock);
        #2 Reset = 1'b1;
        repeat (3) @(negedge Clock);
        chk("abort_wait_idle", 32'(busy[0]), 32'd0);
        start(0, n0);
        push_seq0(6, 6);
        push_rdy(0, n0 + 14 * 7);
        chk("restart_adf", 32'(adf[0]), 32'd0);
        wait_done(200);

        // Inicie held high: next sequence only from IDLE, one cycle after DONE.
        @(negedge Clock);
        inicie[0] = 1'b1;
        @(negedge Clock);
        n0 = cyc;
        push_seq0(6, 6);
        push_seq0(6, 6);
        push_rdy(0, n0 + 98);
        push_rdy(0, n0 + 198);
        while (cyc < n0 + 99) @(negedge Clock);
        chk("held_idle_gap", 32'(busy[0]), 32'd0);
        @(negedge Clock);
        chk("held_restart", 32'(busy[0]), 32'd1);
        while (cyc < n0 + 198) @(negedge Clock);
        inicie[0] = 1'b0;
        wait_done(50);
        repeat (5) @(negedge Clock);
        chk("held_stopped", 32'(busy[0]), 32'd0);

        chk("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
        chk("we_queue_empty", 32'(exp_we.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rtc_read_sequencer.md
RTC_READ_SEQUENCER -- requirements
Module: rtc_read_sequencer

Interface
REQ-001 Parameter TW, default 4: RD/WR strobe low width in Clock cycles; legal range 2..15.
REQ-002 Clock  in  1  single clock; all state changes on its rising edge.
REQ-003 Reset  in  1  asynchronous, active-low; low forces every output to its idle value immediately.
REQ-004 Inicie  in  1  start request, sampled in IDLE only.
REQ-005 DatoBusIn  in  8  data driven by the RTC during read strobes.
REQ-006 ADF, CSF, RDF, WRF  out  1 each  RTC control lines, all active-low except ADF (0 = address phase, 1 = data phase).
REQ-007 DireccionF  out  8  byte driven onto the RTC bus during write phases.
REQ-008 SDF  out  1  bus-drive enable; 1 = DireccionF drives the RTC bus.
REQ-009 AddRegF  out  4  destination index in the local date/time register file.
REQ-010 DatoRegF  out  8  captured byte for the register file.
REQ-011 WeRegF  out  1  one-cycle register-file write strobe.
REQ-012 BusyF  out  1  high from the first SETUP cycle through the final RECOVER cycle.
REQ-013 ReadyF  out  1  one-cycle pulse at sequence completion.

Function
REQ-014 Top-level FSM states SHALL be IDLE, CMD_A, CMD_D, RD_A, RD_D and DONE; each transfer state runs the sub-phases SETUP (1 cycle), STROBE (TW cycles), HOLD (1 cycle) and RECOVER (1 cycle).
REQ-015 Idle bus values SHALL be ADF=1, CSF=1, RDF=1, WRF=1, SDF=0, DireccionF=8'h00, WeRegF=0, DatoRegF=8'h00, AddRegF=0.
REQ-016 IDLE with Inicie=1 at a rising edge SHALL go to CMD_A; SETUP of CMD_A starts the next cycle.
REQ-017 In SETUP, HOLD and STROBE, CSF SHALL be 0; in RECOVER, CSF SHALL be 1.
REQ-018 ADF SHALL be 0 in *_A states and 1 in *_D states for all four sub-phases.
REQ-019 CMD_A SHALL write address 8'hF0 (RTC-to-RAM transfer command) with SDF=1, WRF=0 during STROBE only.
REQ-020 CMD_D SHALL write dummy data 8'h00 with SDF=1, WRF=0 during STROBE only.
REQ-021 RD_A SHALL write address 8'h21+idx with SDF=1, WRF=0 during STROBE, where idx is a 3-bit counter 0..5.
REQ-022 RD_D SHALL hold SDF=0 and drive RDF=0 during STROBE.
REQ-023 In RD_D, DatoBusIn SHALL be registered on the last STROBE cycle.
REQ-024 In the HOLD cycle of RD_D, WeRegF SHALL be 1 for exactly one cycle, with AddRegF=idx and DatoRegF=the captured byte.
REQ-025 After the RECOVER cycle of RD_D, idx<5 SHALL increment idx and return to RD_A; idx=5 SHALL go to DONE.
REQ-026 Register map: idx 0..5 SHALL map to addresses 21..26h (seconds, minutes, hours, day, month, year).
REQ-027 DONE SHALL last one cycle with ReadyF=1, then return to IDLE with idx cleared.
REQ-028 Transfer length SHALL be TW+3 cycles; a sequence SHALL have 14 transfers.
REQ-029 ReadyF SHALL assert exactly 14*(TW+3)+1 cycles after the edge that sampled Inicie.
REQ-030 RDF and WRF SHALL never be 0 simultaneously.
REQ-031 SDF SHALL be 0 whenever RDF=0.
REQ-032 Inicie SHALL be ignored while not in IDLE; Inicie held high continuously SHALL restart only from IDLE, one cycle after the DONE pulse.
REQ-033 A sub-phase counter SHALL count 0..TW-1 in STROBE and SHALL be cleared at every sub-phase change.

Reset
REQ-034 Reset=0 SHALL asynchronously force state IDLE, idx=0, sub-phase counter 0, the capture register 8'h00 and all outputs to REQ-015 values; BusyF=0 and ReadyF=0.
REQ-035 Reset asserted mid-transfer SHALL release the bus within the same cycle (CSF=RDF=WRF=1) without emitting WeRegF or ReadyF.
REQ-036 After Reset deassertion the block SHALL wait in IDLE for Inicie.

Verification
REQ-037 TW=4, pulse Inicie one cycle -> WRF low 4 cycles with DireccionF=F0h/ADF=0, then 4 cycles with 00h/ADF=1; ReadyF at cycle 99.
REQ-038 RTC model returns 8'h10+idx on reads -> six WeRegF pulses with (AddRegF, DatoRegF) = (0,10h)..(5,15h), each pulse in the HOLD cycle after the RD strobe.
REQ-039 Inicie re-pulsed at cycle 40 -> sequence unaffected; ReadyF pulses exactly once, at cycle 99.
REQ-040 Reset low during RD_D STROBE of idx=3 -> CSF/RDF go high immediately, no further WeRegF; next Inicie restarts at CMD_A with idx=0.
REQ-041 TW=2 and TW=15 -> strobe widths of 2 and 15 cycles; ReadyF at cycle 71 (TW=2) and cycle 253 (TW=15).
REQ-042 Assertion monitor, all runs -> never RDF=WRF=0; never SDF=1 with RDF=0; CSF=1 whenever RDF=1 and WRF=1 outside SETUP/HOLD.
